// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: forwarding select and hazard FSM encodings shared with the datapath operand muxes
package hazard_unit_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks one ALU operand source, the younger Memory-stage writer winning over Writeback
module fwd_select
   import hazard_unit_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] wr_m,
   input  logic       we_m,
   input  logic [4:0] wr_w,
   input  logic       we_w,
   output logic [1:0] sel
);

   always_comb
      sel = (we_m && wr_m != 5'd0 && wr_m == src) ? FWD_MEM :
            (we_w && wr_w != 5'd0 && wr_w == src) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush/forwarding control with a data-memory wait FSM and stall counter
module hazard_unit
   import hazard_unit_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic [4:0]  rsE,
   input  logic [4:0]  rtE,
   input  logic [4:0]  rdE,
   input  logic        RFWEE,
   input  logic        MtoRFSelE,
   input  logic        RFDSelE,
   input  logic        BranchE,
   input  logic        BranchTakenE,
   input  logic        DMBusyM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic [1:0]  FwdAE,
   output logic [1:0]  FwdBE,
   output logic [15:0] StallCount
);

   state_t     state, state_nx;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RFWEM, RFWEW, load_use, br_taken;

   assign WriteRegE = RFDSelE ? rdE : rtE;

   always_ff @(posedge clk or posedge clr)
      if (clr) state <= RUN;
      else     state <= state_nx;

   // A memory wait overrides everything; branch beats load-use
   always_comb begin
      state_nx = state;
      case (state)
         RUN:      if (DMBusyM)  state_nx = MEM_WAIT;
         MEM_WAIT: if (!DMBusyM) state_nx = RUN;
      endcase
      load_use = MtoRFSelE && RFWEE && WriteRegE != 5'd0 && (WriteRegE == rsD || WriteRegE == rtD);
      br_taken = BranchE && BranchTakenE;
      StallM   = DMBusyM;
      StallE   = DMBusyM;
      StallF   = DMBusyM || (load_use && !br_taken);
      StallD   = StallF;
      FlushD   = !DMBusyM && br_taken;
      FlushE   = !DMBusyM && (br_taken || load_use);
   end

   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         WriteRegM  <= 5'd0;
         RFWEM      <= 1'b0;
         WriteRegW  <= 5'd0;
         RFWEW      <= 1'b0;
         StallCount <= 16'd0;
      end else begin
         if (!DMBusyM) begin
            WriteRegM <= FlushE ? 5'd0 : WriteRegE;
            RFWEM     <= RFWEE && !FlushE;
            WriteRegW <= WriteRegM;
            RFWEW     <= RFWEM;
         end
         if (StallF && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      end

   fwd_select u_fwd_a (.src(rsE), .wr_m(WriteRegM), .we_m(RFWEM), .wr_w(WriteRegW), .we_w(RFWEW), .sel(FwdAE));
   fwd_select u_fwd_b (.src(rtE), .wr_m(WriteRegM), .we_m(RFWEM), .wr_w(WriteRegW), .we_w(RFWEW), .sel(FwdBE));

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit against a cycle-level reference model
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   logic        clk = 1'b0;
   logic        clr;
   logic [4:0]  rsD, rtD, rsE, rtE, rdE;
   logic        RFWEE, MtoRFSelE, RFDSelE, BranchE, BranchTakenE, DMBusyM;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [1:0]  FwdAE, FwdBE;
   logic [15:0] StallCount;

   int total = 0;
   int bad = 0;

   // Reference model: the two in-flight writers (slot 0 = Memory, 1 = Writeback)
   logic [4:0] trk_reg [2];
   logic       trk_we [2];
   int         m_cnt;
   logic       m_wait;

   hazard_unit dut (
      .clk(clk), .clr(clr), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .rdE(rdE),
      .RFWEE(RFWEE), .MtoRFSelE(MtoRFSelE), .RFDSelE(RFDSelE), .BranchE(BranchE),
      .BranchTakenE(BranchTakenE), .DMBusyM(DMBusyM), .StallF(StallF), .StallD(StallD),
      .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
      .FwdAE(FwdAE), .FwdBE(FwdBE), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] src);
      for (int s = 0; s < 2; s++)
         if (trk_we[s] && trk_reg[s] != 5'd0 && trk_reg[s] == src) return s == 0 ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      trk_reg = '{5'd0, 5'd0};
      trk_we  = '{1'b0, 1'b0};
      m_cnt   = 0;
      m_wait  = 1'b0;
   endtask

   task automatic zero_in();
      {rsD, rtD, rsE, rtE, rdE} = '0;
      {RFWEE, MtoRFSelE, RFDSelE, BranchE, BranchTakenE, DMBusyM} = '0;
   endtask

   task automatic step();
      logic [4:0] wr;
      logic lu, br, busy, e_stall, e_flush;
      if (clr) model_reset();
      #1;
      wr      = RFDSelE ? rdE : rtE;
      lu      = MtoRFSelE && RFWEE && wr != 5'd0 && (wr == rsD || wr == rtD);
      br      = BranchE && BranchTakenE;
      busy    = DMBusyM;
      e_stall = busy || (lu && !br);
      e_flush = !busy && (br || lu);
      chk("StallF", {15'd0, StallF}, {15'd0, e_stall});
      chk("StallD", {15'd0, StallD}, {15'd0, e_stall});
      chk("StallE", {15'd0, StallE}, {15'd0, busy});
      chk("StallM", {15'd0, StallM}, {15'd0, busy});
      chk("FlushD", {15'd0, FlushD}, {15'd0, !busy && br});
      chk("FlushE", {15'd0, FlushE}, {15'd0, e_flush});
      chk("FwdAE", {14'd0, FwdAE}, {14'd0, fwd_ref(rsE)});
      chk("FwdBE", {14'd0, FwdBE}, {14'd0, fwd_ref(rtE)});
      chk("StallCount", StallCount, m_cnt[15:0]);
      chk("state", {15'd0, dut.state == MEM_WAIT}, {15'd0, m_wait});
      @(posedge clk);
      if (clr) model_reset();
      else begin
         if (!busy) begin
            trk_reg[1] = trk_reg[0];
            trk_we[1]  = trk_we[0];
            trk_reg[0] = e_flush ? 5'd0 : wr;
            trk_we[0]  = RFWEE && !e_flush;
         end
         if (e_stall && m_cnt < 65535) m_cnt++;
         m_wait = busy;
      end
      #2;
   endtask

   initial begin
      clr = 1'b1;
      zero_in();
      model_reset();
      #2;
      step();
      chk("rst_fwd", {12'd0, FwdAE, FwdBE}, 16'd0);
      clr = 1'b0;

      zero_in(); MtoRFSelE = 1; RFWEE = 1; rtE = 5; rsD = 5;
      #1;
      chk("lu_stallf", {15'd0, StallF}, 16'd1);
      chk("lu_flushe", {15'd0, FlushE}, 16'd1);
      step();
      chk("lu_count", StallCount, 16'd1);
      zero_in(); step();
      chk("lu_clean_count", StallCount, 16'd1);

      zero_in(); RFWEE = 1; RFDSelE = 1; rdE = 7; step();
      zero_in(); rsE = 7;
      #1 chk("fwd_mem", {14'd0, FwdAE}, 16'd2);
      step();
      zero_in(); rtE = 7;
      #1 chk("fwd_wb", {14'd0, FwdBE}, 16'd1);
      step();

      zero_in(); RFWEE = 1; RFDSelE = 1; rdE = 3; step();
      zero_in(); RFWEE = 1; RFDSelE = 1; rdE = 3; step();
      zero_in(); rsE = 3;
      #1 chk("fwd_double", {14'd0, FwdAE}, 16'd2);
      step();
      zero_in(); RFWEE = 1; RFDSelE = 1; rdE = 0; step();
      zero_in();
      #1 chk("fwd_r0", {12'd0, FwdAE, FwdBE}, 16'd0);
      step();

      zero_in(); MtoRFSelE = 1; RFWEE = 1; rtE = 9; rsD = 9; BranchE = 1; BranchTakenE = 1;
      #1 chk("br_lu", {13'd0, FlushD, FlushE, StallF}, 16'b110);
      step();

      clr = 1'b1; zero_in(); step(); clr = 1'b0;
      zero_in(); RFWEE = 1; RFDSelE = 1; rdE = 4; step();
      zero_in(); RFWEE = 1; RFDSelE = 1; rdE = 6; step();
      for (int i = 0; i < 3; i++) begin
         zero_in(); DMBusyM = 1; RFWEE = 1; RFDSelE = 1; rdE = 11; rsE = 6; rtE = 4;
         step();
         chk("wait_frozen", {12'd0, FwdAE, FwdBE}, 16'b1001);
         chk("wait_stalls", {12'd0, StallF, StallD, StallE, StallM}, 16'hF);
      end
      chk("wait_count", StallCount, 16'd3);
      zero_in(); rsE = 6; step();
      chk("wait_run", {15'd0, dut.state == MEM_WAIT}, 16'd0);

      zero_in(); DMBusyM = 1; step(); step();
      chk("pre_rst_wait", {15'd0, dut.state == MEM_WAIT}, 16'd1);
      clr = 1'b1;
      #1;
      chk("rst_state", {15'd0, dut.state == MEM_WAIT}, 16'd0);
      chk("rst_count", StallCount, 16'd0);
      step();
      clr = 1'b0;
      step();
      chk("post_rst_stalls", {12'd0, StallF, StallD, StallE, StallM}, 16'hF);

      for (int i = 0; i < 400; i++) begin
         rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
         rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
         rdE = 5'($urandom_range(0, 3));
         RFWEE = 1'($urandom); MtoRFSelE = 1'($urandom); RFDSelE = 1'($urandom);
         BranchE = 1'($urandom); BranchTakenE = 1'($urandom);
         DMBusyM = $urandom_range(0, 3) == 0;
         clr = $urandom_range(0, 63) == 0;
         step();
         clr = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
